// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data-memory port: CPU (A) vs loader/DMA (B).
// Default: round-robin with bounded locked B bursts; define DMEM_ARB_CPU_PRIO_EN for strict A priority.
module dmem_arbiter #(
  parameter int unsigned DBITS    = 16,
  parameter int unsigned ABITS    = 12,
  parameter int unsigned MAXBURST = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             A_REQ,
  input  logic             A_WE,
  input  logic [DBITS-1:0] A_ADDR,
  input  logic [DBITS-1:0] A_WDATA,
  output logic             A_GNT,
  output logic             A_RVALID,
  output logic [DBITS-1:0] A_RDATA,
  input  logic             B_REQ,
  input  logic             B_WE,
  input  logic [DBITS-1:0] B_ADDR,
  input  logic [DBITS-1:0] B_WDATA,
  input  logic             B_LOCK,
  output logic             B_GNT,
  output logic             B_RVALID,
  output logic [DBITS-1:0] B_RDATA,
  output logic [ABITS-1:0] MEM_ADDR,
  output logic [DBITS-1:0] MEM_DIN,
  output logic             MEM_WE,
  input  logic [DBITS-1:0] MEM_DOUT,
  output logic             OWNER
);

  localparam logic [3:0]       MaxCnt  = 4'(MAXBURST);
  localparam logic [DBITS-1:0] OorData = DBITS'(16'hDEAD);

  typedef enum logic [1:0] {StIdle, StGa, StGb, StGbl} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       rd_pend_a_q, rd_pend_a_d;
  logic       rd_pend_b_q, rd_pend_b_d;
  logic       rd_oor_a_q, rd_oor_a_d;
  logic       rd_oor_b_q, rd_oor_b_d;

  logic a_win, b_win;
  logic a_gnt, b_gnt;
  logic a_in_range, b_in_range;

  // Byte address bit 0 is ignored: word accesses only.
  logic unused_addr;
  assign unused_addr = A_ADDR[0] ^ B_ADDR[0];

  assign a_in_range = (A_ADDR[DBITS-1:ABITS+1] == '0);
  assign b_in_range = (B_ADDR[DBITS-1:ABITS+1] == '0);

`ifdef DMEM_ARB_CPU_PRIO_EN
  logic unused_lock;
  assign unused_lock = B_LOCK;
`endif

  // Winner selection
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (A_REQ && B_REQ) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
      a_win = 1'b1;
`else
      if (state_q == StGbl) begin
        if (burst_cnt_q < MaxCnt) begin
          b_win = 1'b1;
        end else begin
          a_win = 1'b1;
        end
      end else if (owner_q) begin
        a_win = 1'b1;
      end else begin
        b_win = 1'b1;
      end
`endif
    end else begin
      a_win = A_REQ;
      b_win = B_REQ;
    end
  end

  // Grants are suppressed for the whole time reset is held.
  assign a_gnt = a_win & ~RESET;
  assign b_gnt = b_win & ~RESET;
  assign A_GNT = a_gnt;
  assign B_GNT = b_gnt;

  // Memory port follows the winner; A drives it when nobody is granted.
  always_comb begin
    if (b_win) begin
      MEM_ADDR = B_ADDR[ABITS:1];
      MEM_DIN  = B_WDATA;
    end else begin
      MEM_ADDR = A_ADDR[ABITS:1];
      MEM_DIN  = A_WDATA;
    end
    MEM_WE = (a_gnt & A_WE & a_in_range) | (b_gnt & B_WE & b_in_range);
  end

  // Next-state
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (a_gnt) begin
      state_d     = StGa;
      owner_d     = 1'b0;
      burst_cnt_d = '0;
    end else if (b_gnt) begin
      owner_d = 1'b1;
`ifdef DMEM_ARB_CPU_PRIO_EN
      state_d     = StGb;
      burst_cnt_d = '0;
`else
      if (B_LOCK) begin
        state_d     = StGbl;
        burst_cnt_d = (burst_cnt_q >= MaxCnt) ? MaxCnt : burst_cnt_q + 4'd1;
      end else begin
        state_d     = StGb;
        burst_cnt_d = '0;
      end
`endif
    end else begin
      state_d = StIdle;
`ifdef DMEM_ARB_CPU_PRIO_EN
      burst_cnt_d = '0;
`else
      if (!B_LOCK) begin
        burst_cnt_d = '0;
      end
`endif
    end
  end

  always_comb begin
    rd_pend_a_d = a_gnt & ~A_WE;
    rd_pend_b_d = b_gnt & ~B_WE;
    rd_oor_a_d  = a_gnt & ~A_WE & ~a_in_range;
    rd_oor_b_d  = b_gnt & ~B_WE & ~b_in_range;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      owner_q     <= 1'b1;
      burst_cnt_q <= '0;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
      rd_oor_a_q  <= 1'b0;
      rd_oor_b_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_a_q <= rd_pend_a_d;
      rd_pend_b_q <= rd_pend_b_d;
      rd_oor_a_q  <= rd_oor_a_d;
      rd_oor_b_q  <= rd_oor_b_d;
    end
  end

  assign OWNER    = owner_q;
  assign A_RVALID = rd_pend_a_q;
  assign B_RVALID = rd_pend_b_q;

  always_comb begin
    A_RDATA = '0;
    B_RDATA = '0;
    if (rd_pend_a_q) begin
      A_RDATA = rd_oor_a_q ? OorData : MEM_DOUT;
    end
    if (rd_pend_b_q) begin
      B_RDATA = rd_oor_b_q ? OorData : MEM_DOUT;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a synchronous-RAM model on the memory port.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam bit Prio = 1'b1;
`else
  localparam bit Prio = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we, b_lock;
  logic [15:0] a_addr, a_wd, b_addr, b_wd;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we, owner;
  logic [15:0] a_rdata, b_rdata, mem_din;
  logic [15:0] mem_dout = 16'h0;
  logic [11:0] mem_addr;

  logic [15:0] mem [4096];
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        push_en   = 1'b1;
  logic        chk_maddr = 1'b0;
  logic [11:0] exp_maddr = 12'h0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DBITS(16), .ABITS(12), .MAXBURST(4)) dut (
    .CLK     (clk),
    .RESET   (rst),
    .A_REQ   (a_req),
    .A_WE    (a_we),
    .A_ADDR  (a_addr),
    .A_WDATA (a_wd),
    .A_GNT   (a_gnt),
    .A_RVALID(a_rvalid),
    .A_RDATA (a_rdata),
    .B_REQ   (b_req),
    .B_WE    (b_we),
    .B_ADDR  (b_addr),
    .B_WDATA (b_wd),
    .B_LOCK  (b_lock),
    .B_GNT   (b_gnt),
    .B_RVALID(b_rvalid),
    .B_RDATA (b_rdata),
    .MEM_ADDR(mem_addr),
    .MEM_DIN (mem_din),
    .MEM_WE  (mem_we),
    .MEM_DOUT(mem_dout),
    .OWNER   (owner)
  );

  // Synchronous RAM: read-before-write, one cycle read latency.
  initial begin
    logic [15:0] rd;
    for (int i = 0; i < 4096; i++) mem[i] = {4'hC, 12'(i)};
    forever begin
      @(posedge clk);
      rd = mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_din;
      mem_dout <= rd;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read return is presented.
  always @(negedge clk) begin
    logic [15:0] e;
    n_chk++;
    if (a_rvalid) begin
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_rvalid_unexpected: got data %h expected no RVALID", a_rdata);
      end else begin
        e = qa.pop_front();
        if (a_rdata !== e) begin
          n_fail++;
          $display("FAIL a_rdata: got %h expected %h", a_rdata, e);
        end
      end
    end else if (a_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL a_rdata_idle: got %h expected 0000", a_rdata);
    end
    n_chk++;
    if (b_rvalid) begin
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_rvalid_unexpected: got data %h expected no RVALID", b_rdata);
      end else begin
        e = qb.pop_front();
        if (b_rdata !== e) begin
          n_fail++;
          $display("FAIL b_rdata: got %h expected %h", b_rdata, e);
        end
      end
    end else if (b_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL b_rdata_idle: got %h expected 0000", b_rdata);
    end
  end

  // One cycle: current inputs applied, expected grant/write checked at negedge.
  task automatic step(input string nm, input logic ega, input logic egb, input logic ewe,
                      input logic [15:0] erd);
    if (push_en && ega && !a_we) qa.push_back(erd);
    if (push_en && egb && !b_we) qb.push_back(erd);
    @(negedge clk);
    chk({nm, " a_gnt"}, {15'h0, a_gnt}, {15'h0, ega});
    chk({nm, " b_gnt"}, {15'h0, b_gnt}, {15'h0, egb});
    chk({nm, " mem_we"}, {15'h0, mem_we}, {15'h0, ewe});
    if (chk_maddr) chk({nm, " mem_addr"}, {4'h0, mem_addr}, {4'h0, exp_maddr});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] lock_b;
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0040; a_wd = 16'h1234;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0100; b_wd = 16'h5555; b_lock = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with both requesting: nothing may be granted or written.
    step("rst0", 1'b0, 1'b0, 1'b0, 16'h0);
    chk("rst_owner", {15'h0, owner}, 16'h1);
    chk("rst_rvalid", {14'h0, a_rvalid, b_rvalid}, 16'h0);

    // Release: A wins the first cycle and its store hits word 0x020.
    rst = 1'b0; b_we = 1'b0;
    chk_maddr = 1'b1; exp_maddr = 12'h020;
    step("st_a", 1'b1, 1'b0, 1'b1, 16'h0);
    chk_maddr = 1'b0;
    chk("owner_after_a", {15'h0, owner}, 16'h0);
    a_we = 1'b0;
    step("c1", Prio, !Prio, 1'b0, Prio ? 16'h1234 : 16'hC080);
    if (Prio) a_req = 1'b0; else b_req = 1'b0;
    step("c2", !Prio, Prio, 1'b0, Prio ? 16'hC080 : 16'h1234);
    a_req = 1'b0; b_req = 1'b0;
    step("idle1", 1'b0, 1'b0, 1'b0, 16'h0);

    // Continuous loads from both, unlocked: alternation starting with B.
    a_req = 1'b1; b_req = 1'b1; b_addr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      logic eb;
      eb = !Prio && (i % 2 == 0);
      step("rr", !eb, eb, 1'b0, eb ? 16'hC100 : 16'h1234);
    end
    a_req = 1'b0; b_req = 1'b0;
    step("idle2", 1'b0, 1'b0, 1'b0, 16'h0);

    // Locked burst: B,B,B,B,A,B,B,B,B,A.
    lock_b = Prio ? 10'b0000000000 : 10'b0111101111;
    a_req = 1'b1; b_req = 1'b1; b_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("lock", !lock_b[i], lock_b[i], 1'b0, lock_b[i] ? 16'hC100 : 16'h1234);
    end
    a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    step("idle3", 1'b0, 1'b0, 1'b0, 16'h0);

    // Out-of-range: store discarded (word 0 untouched), load returns DEAD.
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h4000; a_wd = 16'hBEEF;
    step("oor_st", 1'b1, 1'b0, 1'b0, 16'h0);
    a_we = 1'b0; a_addr = 16'hFFF0;
    step("oor_ld", 1'b1, 1'b0, 1'b0, 16'hDEAD);
    a_addr = 16'h0000;
    step("ld_w0", 1'b1, 1'b0, 1'b0, 16'hC000);
    a_req = 1'b0;
    step("idle4", 1'b0, 1'b0, 1'b0, 16'h0);

    // B load granted, then reset lands on its RVALID cycle and on a B store.
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0200;
    push_en = 1'b0;
    step("b_ld", 1'b0, 1'b1, 1'b0, 16'h0);
    push_en = 1'b1;
    rst = 1'b1; b_we = 1'b1; b_addr = 16'h0300; b_wd = 16'h7777;
    step("rst_st", 1'b0, 1'b0, 1'b0, 16'h0);
    rst = 1'b0; b_we = 1'b0;
    step("b_ld2", 1'b0, 1'b1, 1'b0, 16'hC180);
    b_req = 1'b0;
    step("idle5", 1'b0, 1'b0, 1'b0, 16'h0);
    step("idle6", 1'b0, 1'b0, 1'b0, 16'h0);

    chk("qa_drained", 16'(qa.size()), 16'h0);
    chk("qb_drained", 16'(qb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the single data port of the 16-bit pipeline's main memory array. It shares that port between the CPU's MEM-stage load/store (master A) and an auxiliary bus master (master B: program loader / DMA). Arbitration is round-robin with bounded locked bursts for B. The block drives the memory port directly and returns read data one cycle after grant.

## Interface
Parameters:
- DBITS, 16, data and byte-address width
- ABITS, 12, memory word-address width (MEM_ADDR = ADDR[ABITS:1])
- MAXBURST, 4, max consecutive locked B grants while A waits (1..15)

Ports:
- CLK  in  1  sole clock, all state on posedge
- RESET  in  1  asynchronous, active-high
- A_REQ  in  1  CPU access request, held until A_GNT
- A_WE  in  1  1 = store, 0 = load
- A_ADDR  in  DBITS  byte address
- A_WDATA  in  DBITS  store data
- A_GNT  out  1  access accepted this cycle
- A_RVALID  out  1  load data valid (cycle after load grant)
- A_RDATA  out  DBITS  load data
- B_REQ, B_WE, B_ADDR, B_WDATA, B_GNT, B_RVALID, B_RDATA: same as A, for master B
- B_LOCK  in  1  B requests burst ownership
- MEM_ADDR  out  ABITS  memory word address
- MEM_DIN  out  DBITS  memory write data
- MEM_WE  out  1  memory write enable
- MEM_DOUT  in  DBITS  memory read data, valid one cycle after MEM_ADDR (synchronous RAM)
- OWNER  out  1  registered: 0 = A, 1 = B was last granted

## Operation
- Request rules: a master holds REQ, WE, ADDR, WDATA stable until GNT. One GNT cycle = one access. REQ may drop or change the cycle after GNT.
- GNT is combinational from REQ and registered state. At most one GNT per cycle. The granted master's ADDR, WDATA and WE drive the memory port in the same cycle.
- Range check: in_range = ADDR[DBITS-1:ABITS+1] == 0.
  - MEM_WE = granted WE && in_range.
  - An out-of-range store is acknowledged and discarded.
  - An out-of-range load returns 16'hDEAD.
- FSM states:
  - IDLE: no grant last cycle.
  - GA: last grant to A.
  - GB: last grant to B, unlocked.
  - GBL: B locked.
- Winner selection:
  - Only one REQ: that master wins.
  - Both REQ in IDLE/GA/GB: the master not equal to OWNER wins (round-robin).
  - Both REQ in GBL with burst_cnt < MAXBURST: B wins.
  - Both REQ in GBL with burst_cnt == MAXBURST: A wins exactly once, then B may relock.
- State update on each grant:
  - B granted with B_LOCK=1 moves to GBL and increments burst_cnt (saturating at MAXBURST).
  - B granted with B_LOCK=0 moves to GB and clears burst_cnt.
  - A granted moves to GA and clears burst_cnt.
  - No grant moves to IDLE. burst_cnt is held if B_LOCK still high, cleared otherwise.
- Read return:
  - rd_pend_x and rd_oor_x are registered on a load grant.
  - x_RVALID = rd_pend_x.
  - x_RDATA = rd_oor_x ? 16'hDEAD : MEM_DOUT when valid, 0 otherwise.
- Width rules: ADDR bit 0 is ignored (word access only). No arithmetic on data.

## Timing
- Grant latency: 0 cycles when the requester wins, otherwise the number of cycles lost to the other master.
- Bound: A waits at most MAXBURST cycles (or 1 cycle without lock).
- Store commits at the CLK edge ending the grant cycle.
- Load data: RVALID is high exactly one cycle, the cycle after GNT. Back-to-back loads give continuous RVALID.
- Simultaneous events:
  - A load grant and an RVALID for the previous access may coincide; both are legal.
  - A_REQ and B_REQ rising in the same cycle out of reset: A wins (OWNER resets to 1).
- Reset values: state IDLE, OWNER=1, burst_cnt=0, rd_pend_*=0, rd_oor_*=0.
  - While RESET is high: A_GNT, B_GNT, MEM_WE, A_RVALID and B_RVALID are forced 0, and RDATA is 0.
  - Reset asserted mid-access aborts it: no write commits and the pending RVALID is dropped.
- Deassertion of RESET is synchronous to CLK at the integration level.

## Configuration
- DMEM_ARB_CPU_PRIO_EN defined:
  - A has strict priority. When both request, A always wins.
  - B_LOCK is ignored and GBL is unreachable. B is served only in cycles with A_REQ=0.
- Not defined (default): round-robin plus bounded locked bursts as specified above.

## Test plan
- Reset: hold RESET with A_REQ=B_REQ=1 -> all GNT, MEM_WE and RVALID are 0. Release -> A_GNT in first cycle, OWNER=0 next.
- A store 0x1234 to 0x0040, then A load 0x0040 -> MEM_WE=1 with MEM_ADDR=0x020 in cycle 0. Load GNT in cycle 1, A_RVALID=1 with A_RDATA=0x1234 in cycle 2.
- Both masters request continuous loads, B_LOCK=0 -> GNT alternates A,B,A,B. Each RVALID is one cycle after its own GNT.
- B_LOCK=1, MAXBURST=4, both requesting -> pattern B,B,B,B,A,B,B,B,B,A. A never waits more than 4 cycles.
- Store to 0x4000 and load from 0xFFF0 -> GNT given, MEM_WE=0, load returns 0xDEAD with RVALID.
- RESET pulsed during a B store grant -> memory location unchanged, B_RVALID stays 0. DMEM_ARB_CPU_PRIO_EN build: both request -> A granted every cycle.
